waveform_analyzer: RTL and testbench

Capture-side counterpart of the waveform generator. It consumes the 8-bit sample stream that the generator drives onto its output wave bus, and measures one full period per request. For each period it reports the length in samples and the minimum and maximum sample values, plus an optional shape class. It sits on the same oscillator clock as the generator and feeds the self-check and display logic.

---
 rtl/wave_pkg.sv | 28 ++
 rtl/waveform_analyzer_if.sv | 32 +++
 rtl/hyst_comparator.sv | 35 +++
 rtl/waveform_analyzer.sv | 156 +++++++++++++++
 tb/tb_waveform_analyzer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/wave_pkg.sv
// Shared types and default constants for the waveform analyzer and generator.
// The WAVE_CLASSIFY_EN build option is consumed by waveform_analyzer.
package wave_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  typedef enum logic [2:0] {
    WC_NONE   = 3'd0,
    WC_SMOOTH = 3'd1,
    WC_SAW    = 3'd2,
    WC_SQUARE = 3'd3
  } wave_class_t;

  localparam logic [7:0] THRESH_DEF   = 8'd128;
  localparam int         HYST_DEF     = 4;
  localparam int         PERIOD_W_DEF = 16;
  localparam int         JUMP_TH      = 64;

  // Zero jumps is smooth, one is sawtooth, two or more is square.
  function automatic wave_class_t class_of(input logic [1:0] jumps);
    case (jumps)
      2'd0:    return WC_SMOOTH;
      2'd1:    return WC_SAW;
      default: return WC_SQUARE;
    endcase
  endfunction

endpackage

// File: rtl/waveform_analyzer_if.sv
// Sample-stream and result bus of the waveform analyzer.
// sample_valid qualifies sample in the same cycle; there is no backpressure.
interface waveform_analyzer_if
  import wave_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF
);
  logic                init;
  logic                sample_valid;
  logic [7:0]          sample;
  logic                busy;
  logic                meas_done;
  logic                timeout;
  logic [PERIOD_W-1:0] period;
  logic [7:0]          max_val;
  logic [7:0]          min_val;
  logic [2:0]          wave_class;
  state_t              dbg_state;
  logic                dbg_level;

  modport master (
    output init, sample_valid, sample,
    input  busy, meas_done, timeout, period, max_val, min_val, wave_class,
    input  dbg_state, dbg_level
  );

  modport slave (
    input  init, sample_valid, sample,
    output busy, meas_done, timeout, period, max_val, min_val, wave_class,
    output dbg_state, dbg_level
  );
endinterface

// File: rtl/hyst_comparator.sv
// Threshold comparator with hysteresis; level updates only on valid samples.
// The rise strobe is combinational so the crossing sample is acted on in its own cycle.
module hyst_comparator #(
  parameter logic [7:0] THRESH = 8'd128,
  parameter int         HYST   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sample_valid,
  input  logic [7:0] i_sample,
  output logic       o_level,
  output logic       o_rise
);
  localparam logic [7:0] HI = THRESH + 8'(HYST);
  localparam logic [7:0] LO = THRESH - 8'(HYST);

  logic r_level;
  logic w_hi;
  logic w_lo;

  assign w_hi = (i_sample >= HI);
  assign w_lo = (i_sample <= LO);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= 1'b0;
    end else if (i_sample_valid) begin
      if (w_hi)      r_level <= 1'b1;
      else if (w_lo) r_level <= 1'b0;
    end
  end

  assign o_level = r_level;
  assign o_rise  = i_sample_valid && !r_level && w_hi;
endmodule

// File: rtl/waveform_analyzer.sv
// Measures one waveform period (length, min, max) per INIT request.
// Define WAVE_CLASSIFY_EN to build the jump-count shape classifier.
module waveform_analyzer
  import wave_pkg::*;
#(
  parameter logic [7:0] THRESH   = THRESH_DEF,
  parameter int         HYST     = HYST_DEF,
  parameter int         PERIOD_W = PERIOD_W_DEF
) (
  input logic          i_clk,
  input logic          i_rst_n,
  waveform_analyzer_if.slave bus
);
  state_t              r_state, w_next;
  logic [PERIOD_W-1:0] r_count, w_count_inc, r_period;
  logic [7:0]          r_min, r_max, w_min_upd, w_max_upd;
  logic [7:0]          r_min_val, r_max_val;
  logic                r_timeout;
  logic                w_rise, w_level, w_sat;
  logic                w_start, w_load, w_timeout;

  hyst_comparator #(.THRESH(THRESH), .HYST(HYST)) u_cmp (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_sample_valid (bus.sample_valid),
    .i_sample       (bus.sample),
    .o_level        (w_level),
    .o_rise         (w_rise)
  );

  assign w_count_inc = r_count + 1'b1;
  assign w_sat       = (w_count_inc == '1);
  assign w_min_upd   = (bus.sample < r_min) ? bus.sample : r_min;
  assign w_max_upd   = (bus.sample > r_max) ? bus.sample : r_max;

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_load    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: if (bus.init) w_next = ARM;
      ARM: begin
        if (bus.sample_valid) begin
          if (w_rise) begin
            w_start = 1'b1;
            w_next  = MEAS;
          end else if (w_sat) begin
            w_timeout = 1'b1;
            w_next    = IDLE;
          end
        end
      end
      MEAS: begin
        if (bus.sample_valid) begin
          // The closing crossing sample belongs to the window.
          if (w_rise) begin
            w_load = 1'b1;
            w_next = DONE;
          end else if (w_sat) begin
            w_timeout = 1'b1;
            w_next    = IDLE;
          end
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_min     <= 8'h00;
      r_max     <= 8'h00;
      r_timeout <= 1'b0;
      r_period  <= '0;
      r_min_val <= 8'h00;
      r_max_val <= 8'h00;
    end else begin
      r_state   <= w_next;
      r_timeout <= w_timeout;
      case (r_state)
        IDLE: r_count <= '0;
        ARM: begin
          if (bus.sample_valid) begin
            if (w_start) begin
              r_count <= '0;
              r_min   <= 8'hFF;
              r_max   <= 8'h00;
            end else begin
              r_count <= w_count_inc;
            end
          end
        end
        MEAS: begin
          if (bus.sample_valid) begin
            r_count <= w_count_inc;
            r_min   <= w_min_upd;
            r_max   <= w_max_upd;
          end
        end
        default: ;
      endcase
      if (w_load) begin
        r_period  <= w_count_inc;
        r_min_val <= w_min_upd;
        r_max_val <= w_max_upd;
      end
    end
  end

`ifdef WAVE_CLASSIFY_EN
  logic [7:0]        r_prev;
  logic [1:0]        r_jumps, w_jumps_upd;
  logic [2:0]        r_class;
  logic signed [8:0] w_diff;
  logic [8:0]        w_abs;
  logic              w_jump;

  assign w_diff      = $signed({1'b0, bus.sample}) - $signed({1'b0, r_prev});
  assign w_abs       = w_diff[8] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_jump      = (w_abs > 9'(JUMP_TH));
  assign w_jumps_upd = (w_jump && (r_jumps != 2'd3)) ? r_jumps + 2'd1 : r_jumps;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev  <= 8'h00;
      r_jumps <= 2'd0;
      r_class <= WC_NONE;
    end else begin
      if (bus.sample_valid) r_prev <= bus.sample;
      if (w_start) begin
        r_jumps <= 2'd0;
      end else if (r_state == MEAS && bus.sample_valid) begin
        r_jumps <= w_jumps_upd;
      end
      if (w_load) r_class <= class_of(w_jumps_upd);
    end
  end

  assign bus.wave_class = r_class;
`else
  assign bus.wave_class = WC_NONE;
`endif

  assign bus.busy      = (r_state == ARM) || (r_state == MEAS);
  assign bus.meas_done = (r_state == DONE);
  assign bus.timeout   = r_timeout;
  assign bus.period    = r_period;
  assign bus.min_val   = r_min_val;
  assign bus.max_val   = r_max_val;
  assign bus.dbg_state = r_state;
  assign bus.dbg_level = w_level;
endmodule

// File: tb/tb_waveform_analyzer.sv
// Self-checking bench for waveform_analyzer: expected results are queued when
// a measurement is launched and popped when MEAS_DONE is observed.
module tb_waveform_analyzer;
  import wave_pkg::*;

`ifdef WAVE_CLASSIFY_EN
  localparam logic [2:0] CLS_SQ  = 3'd3;
  localparam logic [2:0] CLS_SAW = 3'd2;
`else
  localparam logic [2:0] CLS_SQ  = 3'd0;
  localparam logic [2:0] CLS_SAW = 3'd0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  waveform_analyzer_if #(.PERIOD_W(16)) bus ();

  waveform_analyzer #(.PERIOD_W(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_tout   = 0;
  logic [34:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] p, input logic [7:0] mn, input logic [7:0] mx,
                          input logic [2:0] c);
    exp_q.push_back({p, mn, mx, c});
  endtask

  // driver tasks: inputs change #1 after a rising edge and are consumed at the next one
  task automatic step(input logic init, input logic v, input logic [7:0] s);
    bus.init         = init;
    bus.sample_valid = v;
    bus.sample       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_square(input int n, input bit gap, input bit init_busy);
    logic [7:0] val;
    logic       ini;
    for (int i = 0; i < n; i++) begin
      val = ((i % 10) < 5) ? 8'd0 : 8'd255;
      ini = (i == 0) || (init_busy && i >= 7 && i <= 12);
      step(ini, 1'b1, val);
      if (i == 0) check("busy_rise", bus.busy, 1);
      if (gap) step(1'b0, 1'b0, 8'hAA);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin : monitor
    logic [34:0] e;
    if (rst_n) begin
      if (bus.meas_done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("period", bus.period, e[34:19]);
          check("min_val", bus.min_val, e[18:11]);
          check("max_val", bus.max_val, e[10:3]);
          check("wave_class", bus.wave_class, e[2:0]);
          check("busy_at_done", bus.busy, 0);
        end
      end
      if (bus.timeout) n_tout++;
    end
  end

  initial begin
    bus.init = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.meas_done, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_period", bus.period, 0);
    check("rst_min", bus.min_val, 0);
    check("rst_max", bus.max_val, 0);
    check("rst_class", bus.wave_class, 0);
    check("rst_state", bus.dbg_state, IDLE);
    rst_n = 1'b1;
    idle(2);

    // square wave
    n_done = 0;
    push_exp(16'd10, 8'd0, 8'd255, CLS_SQ);
    run_square(30, 1'b0, 1'b0);
    idle(4);
    check("sq_done_cnt", n_done, 1);
    check("sq_busy_end", bus.busy, 0);

    // sawtooth
    n_done = 0;
    push_exp(16'd16, 8'd0, 8'd240, CLS_SAW);
    for (int i = 0; i < 48; i++) step(i == 0, 1'b1, 8'((i % 16) * 16));
    idle(4);
    check("saw_done_cnt", n_done, 1);

    // gapped valid
    n_done = 0;
    push_exp(16'd10, 8'd0, 8'd255, CLS_SQ);
    run_square(30, 1'b1, 1'b0);
    idle(4);
    check("gap_done_cnt", n_done, 1);

    // INIT while busy
    n_done = 0;
    push_exp(16'd10, 8'd0, 8'd255, CLS_SQ);
    run_square(30, 1'b0, 1'b1);
    idle(4);
    check("initbusy_done_cnt", n_done, 1);

    // reset mid-measurement
    n_done = 0;
    n_tout = 0;
    run_square(10, 1'b0, 1'b0);
    check("mid_state", bus.dbg_state, MEAS);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_period", bus.period, 0);
    check("mid_rst_max", bus.max_val, 0);
    check("mid_rst_state", bus.dbg_state, IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, ((i % 10) < 5) ? 8'd0 : 8'd255);
    idle(2);
    check("mid_no_done", n_done, 0);
    check("mid_no_tout", n_tout, 0);
    push_exp(16'd10, 8'd0, 8'd255, CLS_SQ);
    run_square(30, 1'b0, 1'b0);
    idle(4);
    check("mid_retry_done_cnt", n_done, 1);

    // timeout on a constant input
    n_done = 0;
    n_tout = 0;
    step(1'b1, 1'b1, 8'd100);
    repeat (65534) step(1'b0, 1'b1, 8'd100);
    check("tout_early", n_tout, 0);
    check("tout_busy_before", bus.busy, 1);
    step(1'b0, 1'b1, 8'd100);
    check("tout_pulse", bus.timeout, 1);
    check("tout_busy_after", bus.busy, 0);
    check("tout_period_kept", bus.period, 10);
    check("tout_max_kept", bus.max_val, 255);
    step(1'b0, 1'b0, 8'h00);
    check("tout_one_cycle", bus.timeout, 0);
    idle(3);
    check("tout_cnt", n_tout, 1);
    check("tout_no_done", n_done, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
